// File: rtl/ser_pkg.sv
// Shared types and constants for the word serializer.
// FSM state encoding and the completed-word counter width.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/ser_fifo.sv
// Small power-of-two input FIFO with a registered occupancy count.
// Writes while full and reads while empty are dropped.
module ser_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("ser_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/word_serializer.sv
// Splits IN_W-bit words into OUT_W-bit beats paced by tx_done.
// Define WORD_SERIALIZER_CNT_EN to build the completed-word counter.
module word_serializer
    import ser_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  data_in,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             data_out_valid,
    input  logic             tx_done,
    output logic             word_done,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int BEATS = IN_W / OUT_W;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BEATS - 1);

    generate
        if (IN_W % OUT_W != 0) begin : g_bad_width
            $error("word_serializer: IN_W must be a multiple of OUT_W");
        end
    endgenerate

    state_t          state_q;
    state_t          state_d;
    logic [IN_W-1:0] fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IN_W-1:0] sreg_q;
    logic [IDX_W-1:0] idx_q;
    logic            rdy_q;
    logic            pop;
    logic            issue;
    logic            adv;
    logic            finish;
    logic [OUT_W-1:0] head;
    logic [IN_W-1:0] sreg_next;

    ser_fifo #(
        .WIDTH(IN_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (data_in_valid && data_in_ready),
        .pop  (pop),
        .din  (data_in),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign data_in_ready = rdy_q && !fifo_full;
    assign busy          = (state_q != IDLE);

    assign head = (MSB_FIRST != 0) ? sreg_q[IN_W-1 -: OUT_W]
                                   : sreg_q[OUT_W-1:0];
    assign sreg_next = (MSB_FIRST != 0) ? (sreg_q << OUT_W)
                                        : (sreg_q >> OUT_W);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A tx_done arriving with data_out_valid still high is a stale ack.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        issue   = 1'b0;
        adv     = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                issue   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done && !data_out_valid) begin
                    if (idx_q != LAST) begin
                        issue = 1'b1;
                        adv   = 1'b1;
                    end else begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q          <= 1'b0;
            sreg_q         <= '0;
            idx_q          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            word_done      <= 1'b0;
        end else begin
            rdy_q          <= 1'b1;
            data_out_valid <= issue;
            word_done      <= finish;
            if (pop) begin
                sreg_q <= fifo_dout;
                idx_q  <= '0;
            end else if (issue) begin
                sreg_q   <= sreg_next;
                data_out <= head;
                if (adv) idx_q <= idx_q + 1'b1;
            end
        end
    end

`ifdef WORD_SERIALIZER_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)         cnt_q <= '0;
        else if (finish) cnt_q <= cnt_q + 1'b1;
    end

    assign word_cnt = cnt_q;
`else
    assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench: three serializer configurations share clk/rst.
// Covers beat order, latency, stale acks, FIFO backpressure, reset.
module tb_word_serializer;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic [31:0] a_din, b_din;
    logic [63:0] c_din;
    logic        a_vin, b_vin, c_vin;
    logic        a_rdy, b_rdy, c_rdy;
    logic [7:0]  a_dout, b_dout;
    logic [15:0] c_dout;
    logic        a_dov, b_dov, c_dov;
    logic        a_txr, b_txr, c_txr, a_txf;
    logic        a_tx, b_tx, c_tx;
    logic        a_wd, b_wd, c_wd;
    logic        a_busy, b_busy, c_busy;
    logic [15:0] a_cnt, b_cnt, c_cnt;

    assign a_tx = a_txr | a_txf;
    assign b_tx = b_txr;
    assign c_tx = c_txr;

    word_serializer u_a (
        .clk(clk), .rst(rst), .data_in(a_din), .data_in_valid(a_vin),
        .data_in_ready(a_rdy), .data_out(a_dout), .data_out_valid(a_dov),
        .tx_done(a_tx), .word_done(a_wd), .busy(a_busy), .word_cnt(a_cnt)
    );

    word_serializer #(.MSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .data_in(b_din), .data_in_valid(b_vin),
        .data_in_ready(b_rdy), .data_out(b_dout), .data_out_valid(b_dov),
        .tx_done(b_tx), .word_done(b_wd), .busy(b_busy), .word_cnt(b_cnt)
    );

    word_serializer #(.IN_W(64), .OUT_W(16), .DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .data_in(c_din), .data_in_valid(c_vin),
        .data_in_ready(c_rdy), .data_out(c_dout), .data_out_valid(c_dov),
        .tx_done(c_tx), .word_done(c_wd), .busy(c_busy), .word_cnt(c_cnt)
    );

    logic [7:0]  qa[$], qb[$];
    logic [15:0] qc[$];
    int  wd_a = 0, wd_b = 0, wd_c = 0;
    int  bi_a = 0, bi_b = 0;
    int  gap_a = 0, gap_b = 0;
    int  cd_a = 0, cd_b = 0, cd_c = 0;
    bit  pend_a = 0, pend_b = 0, pend_c = 0;
    bit  glitch_a = 0, en_c = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int expc(input int n);
`ifdef WORD_SERIALIZER_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    // Transmitter models: ack each beat 5 cycles after its start pulse.
    always @(negedge clk) begin
        if (rst) begin
            a_txr = 0; pend_a = 0; cd_a = 0; bi_a = 0; gap_a = 0;
        end else begin
            a_txr = 0;
            if (a_dov) begin
                check("a_unexp", 64'(qa.size() != 0), 1);
                if (qa.size() != 0) check("a_beat", a_dout, qa.pop_front());
                if (bi_a != 0) check("a_gap", gap_a, 6);
                bi_a = (bi_a + 1) % 4;
                gap_a = 0; pend_a = 1; cd_a = 5;
                if (glitch_a) a_txr = 1;
            end else if (pend_a) begin
                cd_a--;
                if (cd_a == 0) begin a_txr = 1; pend_a = 0; end
            end
            gap_a++;
            if (a_wd) wd_a++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_txr = 0; pend_b = 0; cd_b = 0; bi_b = 0; gap_b = 0;
        end else begin
            b_txr = 0;
            if (b_dov) begin
                check("b_unexp", 64'(qb.size() != 0), 1);
                if (qb.size() != 0) check("b_beat", b_dout, qb.pop_front());
                if (bi_b != 0) check("b_gap", gap_b, 6);
                bi_b = (bi_b + 1) % 4;
                gap_b = 0; pend_b = 1; cd_b = 5;
            end else if (pend_b) begin
                cd_b--;
                if (cd_b == 0) begin b_txr = 1; pend_b = 0; end
            end
            gap_b++;
            if (b_wd) wd_b++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            c_txr = 0; pend_c = 0; cd_c = 0;
        end else begin
            c_txr = 0;
            if (c_dov) begin
                check("c_unexp", 64'(qc.size() != 0), 1);
                if (qc.size() != 0) check("c_beat", c_dout, qc.pop_front());
                pend_c = 1; cd_c = 5;
            end else if (pend_c && en_c) begin
                cd_c--;
                if (cd_c == 0) begin c_txr = 1; pend_c = 0; end
            end
            if (c_wd) wd_c++;
        end
    end

    task automatic put_a(input logic [31:0] w);
        a_din = w;
        a_vin = 1;
        for (int k = 0; k < 4; k++) qa.push_back(w[31-8*k -: 8]);
        @(negedge clk);
        a_vin = 0;
    endtask

    task automatic chk_a_reset(input string tag);
        check({tag, "_dout"}, a_dout, 0);
        check({tag, "_dov"}, a_dov, 0);
        check({tag, "_wd"}, a_wd, 0);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_cnt"}, a_cnt, 0);
        check({tag, "_rdy"}, a_rdy, 0);
    endtask

    initial begin
        logic [31:0] w;
        logic [63:0] wc;
        rst = 1;
        a_vin = 0; b_vin = 0; c_vin = 0;
        a_din = 0; b_din = 0; c_din = 0; a_txf = 0;
        repeat (3) @(negedge clk);
        chk_a_reset("rst0");
        check("rst0_c_rdy", c_rdy, 0);
        rst = 0;
        @(negedge clk);
        check("rdy_rise_a", a_rdy, 1);
        check("rdy_rise_c", c_rdy, 1);

        a_txf = 1;
        @(negedge clk);
        a_txf = 0;
        check("idle_tx_busy", a_busy, 0);
        @(negedge clk);
        check("idle_tx_dov", a_dov, 0);

        w = 32'hA1B2C3D4;
        b_din = w;
        b_vin = 1;
        for (int k = 0; k < 4; k++) qb.push_back(w[8*k +: 8]);
        put_a(w);
        b_vin = 0;
        check("lat_t1", a_dov, 0);
        @(negedge clk);
        check("lat_t2", a_dov, 0);
        @(negedge clk);
        check("lat_t3_a", a_dov, 1);
        check("lat_t3_b", b_dov, 1);
        for (int i = 0; i < 300 && (wd_a < 1 || wd_b < 1); i++)
            @(negedge clk);
        check("w1_wd_a", wd_a, 1);
        check("w1_wd_b", wd_b, 1);
        check("w1_cnt_a", a_cnt, expc(1));
        check("w1_cnt_b", b_cnt, expc(1));
        check("w1_busy", a_busy, 0);

        glitch_a = 1;
        put_a(32'h0F1E2D3C);
        for (int i = 0; i < 300 && wd_a < 2; i++) @(negedge clk);
        glitch_a = 0;
        check("w2_wd_a", wd_a, 2);
        check("w2_cnt_a", a_cnt, expc(2));

        put_a(32'h11223344);
        for (int i = 0; i < 300 && bi_a != 2; i++) @(negedge clk);
        check("mid_beats", bi_a, 2);
        repeat (2) @(negedge clk);
        rst = 1;
        qa.delete();
        repeat (2) @(negedge clk);
        chk_a_reset("rst1");
        rst = 0;
        @(negedge clk);
        check("rst1_rdy", a_rdy, 1);
        check("rst1_no_wd", wd_a, 2);

        put_a(32'h55667788);
        for (int i = 0; i < 300 && wd_a < 3; i++) @(negedge clk);
        check("w3_wd_a", wd_a, 3);
        check("w3_cnt_a", a_cnt, expc(1));

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 20 && !c_rdy; k++) begin
                c_vin = 0;
                @(negedge clk);
            end
            check("c_fill_rdy", c_rdy, 1);
            wc = {$urandom, $urandom};
            c_din = wc;
            c_vin = 1;
            for (int k = 0; k < 4; k++) qc.push_back(wc[63-16*k -: 16]);
            @(negedge clk);
        end
        c_vin = 0;
        check("c_full_rdy", c_rdy, 0);
        repeat (10) @(negedge clk);
        check("c_hold_rdy", c_rdy, 0);
        check("c_hold_busy", c_busy, 1);
        check("c_hold_wd", wd_c, 0);
        en_c = 1;
        for (int i = 0; i < 1000 && wd_c < 5; i++) @(negedge clk);
        check("c_wd", wd_c, 5);
        check("c_cnt", c_cnt, expc(5));
        check("c_rdy_end", c_rdy, 1);

        repeat (5) @(negedge clk);
        check("qa_left", qa.size(), 0);
        check("qb_left", qb.size(), 0);
        check("qc_left", qc.size(), 0);
        check("b_wd_end", wd_b, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter IN_W, default 32, input word width in bits.
REQ-002 SHALL have parameter OUT_W, default 8, output beat width in bits; IN_W SHALL be an integer multiple of OUT_W, otherwise elaboration fails.
REQ-003 SHALL have parameter DEPTH, default 2, input FIFO depth in words, power of two, minimum 2.
REQ-004 SHALL have parameter MSB_FIRST, default 1: 1 sends the most significant beat first, 0 sends the least significant beat first.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port data_in, input, IN_W bits: word to serialise.
REQ-008 SHALL have port data_in_valid, input, 1 bit: data_in is valid this cycle.
REQ-009 SHALL have port data_in_ready, output, 1 bit: FIFO can accept a word.
REQ-010 SHALL have port data_out, output, OUT_W bits: current beat, held until the next beat is issued.
REQ-011 SHALL have port data_out_valid, output, 1 bit: one-cycle pulse per beat, the start request to the byte transmitter.
REQ-012 SHALL have port tx_done, input, 1 bit: pulse from the transmitter when the current beat has completed.
REQ-013 SHALL have port word_done, output, 1 bit: one-cycle pulse when the last beat of a word completes.
REQ-014 SHALL have port busy, output, 1 bit: high while the FSM is not in IDLE.
REQ-015 SHALL have port word_cnt, output, 16 bits: count of completed words (see Configuration).

Function
REQ-016 BEATS = IN_W/OUT_W; beat index width = clog2(BEATS), minimum 1.
REQ-017 A word SHALL be written to the FIFO when data_in_valid && data_in_ready; data_in_ready = !full, derived from registered state only, with no combinational path from data_in_valid.
REQ-018 FSM states SHALL be IDLE, LOAD, WAIT.
REQ-019 In IDLE with FIFO non-empty: pop the word into the shift register, then go to LOAD.
REQ-020 In LOAD: register beat 0 onto data_out, pulse data_out_valid, then go to WAIT.
REQ-021 In WAIT on tx_done: if beat index < BEATS-1, increment the index, register the next beat, pulse data_out_valid, and stay in WAIT; otherwise pulse word_done and go to IDLE.
REQ-022 tx_done SHALL be ignored in IDLE and LOAD, and in any cycle where data_out_valid is high.
REQ-023 Latency: a word written into an empty FIFO in cycle t SHALL produce data_out_valid in cycle t+3; back-to-back words SHALL have a 2-cycle gap between word_done and the next data_out_valid.
REQ-024 Beat order: with MSB_FIRST=1, beat k = word[IN_W-1-k*OUT_W -: OUT_W]; with MSB_FIRST=0, beat k = word[k*OUT_W +: OUT_W].
REQ-025 Push and pop in the same cycle SHALL be allowed at any level; the FIFO pointers wrap modulo DEPTH.
REQ-026 A write while full SHALL be impossible, because data_in_ready is low.

Reset
REQ-027 While rst is high: FSM=IDLE, FIFO empty, data_out=0, data_out_valid=0, word_done=0, busy=0, word_cnt=0, data_in_ready=0.
REQ-028 data_in_ready SHALL rise the first cycle after rst deasserts.
REQ-029 Reset mid-word SHALL discard the partial word and all FIFO contents, and no word_done SHALL be issued.

Configuration
REQ-030 Macro WORD_SERIALIZER_CNT_EN defined: word_cnt increments on each word_done and wraps 0xFFFF->0.
REQ-031 Macro WORD_SERIALIZER_CNT_EN undefined: word_cnt is tied to 0 and no counter register exists.

Structure
REQ-032 Package ser_pkg SHALL hold the FSM state enum (IDLE, LOAD, WAIT) and the word_cnt width constant CNT_W=16.
REQ-033 The FIFO SHALL be the sub-module ser_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, registered count).

Verification
REQ-034 Defaults; write 0xA1B2C3D4; answer each data_out_valid with tx_done 5 cycles later -> beats A1,B2,C3,D4, then one word_done pulse, word_cnt=1.
REQ-035 MSB_FIRST=0, same word -> beats D4,C3,B2,A1.
REQ-036 IN_W=64, OUT_W=16, DEPTH=4; write 5 words with tx_done held off -> data_in_ready low after the 4th word queued plus 1 loaded; all 20 beats emitted in order once tx_done resumes.
REQ-037 tx_done pulsed in IDLE and coincident with data_out_valid -> ignored, beat index unchanged.
REQ-038 rst asserted after the 2nd beat of 0x11223344 -> all outputs at reset values; a following word 0x55667788 emits 55,66,77,88 with no stale beats.
REQ-039 Build without WORD_SERIALIZER_CNT_EN, run REQ-034 -> word_cnt stays 0 and all other behaviour is identical.
